// File: rtl/cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// cmd_dispatcher
//
// UART command dispatcher. In idle, a received byte is matched against
// NUM_CH command codes. The lowest matching channel index is activated and
// stays active until that channel raises its done flag or the activity timer
// expires. While a channel is active, its TX byte and start strobe are
// forwarded to the UART transmitter through a registered mux.
//
// Optional feature (macro CMD_DISPATCHER_ACK_EN):
//   When defined, the dispatcher sends its own status byte in a REPLY state
//   after each command: ACK (0x06) after done, CAN (0x18) after a timeout,
//   and NAK (0x15) after an unknown code. When undefined, there is no REPLY
//   state. Unknown codes are then only counted.
//
// Parameters:
//   NUM_CH          number of channels (1..16)
//   CH_CODES        NUM_CH*8-bit code vector; channel k uses bits [8k+7:8k]
//   IDLE_CODE       value shown on 'state' while idle; never a valid command
//   TIMEOUT_CYCLES  maximum active duration in clk cycles; 0 disables it
//   TIMEOUT_W       timer width; must be able to hold TIMEOUT_CYCLES
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   rx_ready     one-cycle strobe: rx_data is valid
//   rx_data      received byte
//   ch_activate  one-hot channel enable
//   ch_done      per-channel finished flags (only the active one is used)
//   ch_tx_data   per-channel TX byte, channel k at [8k+7:8k]
//   ch_tx_start  per-channel TX start strobe
//   tx_data      byte to uart_tx
//   tx_start     start strobe to uart_tx
//   tx_active    uart_tx is busy
//   tx_done      uart_tx finished a byte
//   state        active command code, or IDLE_CODE
//   busy         a channel is active, or a reply is in progress
//   err_count    saturating count of unknown codes and timeouts
// -----------------------------------------------------------------------------
module cmd_dispatcher #(
  parameter int                   NUM_CH         = 4,
  parameter logic [NUM_CH*8-1:0]  CH_CODES       = {8'h72, 8'h71, 8'h21, 8'h11},
  parameter logic [7:0]           IDLE_CODE      = 8'hFF,
  parameter int unsigned          TIMEOUT_CYCLES = 50_000_000,
  parameter int                   TIMEOUT_W      = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  output logic [NUM_CH-1:0]     ch_activate,
  input  logic [NUM_CH-1:0]     ch_done,
  input  logic [NUM_CH*8-1:0]   ch_tx_data,
  input  logic [NUM_CH-1:0]     ch_tx_start,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_active,
  input  logic                  tx_done,
  output logic [7:0]            state,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Terminal timer value; the abort happens on the edge that sees it, which
  // is edge TIMEOUT_CYCLES counted from the activation edge.
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

`ifdef CMD_DISPATCHER_ACK_EN
  localparam logic [7:0] BYTE_ACK = 8'h06;
  localparam logic [7:0] BYTE_NAK = 8'h15;
  localparam logic [7:0] BYTE_CAN = 8'h18;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_REPLY  = 2'd2
  } fsm_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1
  } fsm_t;
`endif

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  fsm_t                  fsm_q,     fsm_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [NUM_CH-1:0]     act_q,     act_d;
  logic [7:0]            state_q,   state_d;
  logic [TIMEOUT_W-1:0]  timer_q,   timer_d;
  logic [7:0]            err_q,     err_d;
  logic [7:0]            txd_q,     txd_d;
  logic                  txs_q,     txs_d;
`ifdef CMD_DISPATCHER_ACK_EN
  logic [7:0]            reply_q,   reply_d;
  logic                  sent_q,    sent_d;
`else
  // uart_tx status is only needed when the dispatcher sends replies itself.
  logic                  unused_tx_status;
  assign unused_tx_status = tx_active ^ tx_done;
`endif

  // Per-channel TX bytes unpacked for indexed access.
  logic [7:0] ch_bytes [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_bytes[g] = ch_tx_data[8*g +: 8];
  end

  // ---------------------------------------------------------------------------
  // Code decoder: lowest matching index wins; IDLE_CODE never matches.
  // ---------------------------------------------------------------------------
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    hit     = 1'b0;
    hit_idx = '0;
    if (rx_data != IDLE_CODE) begin
      // Descending scan so the last assignment is the lowest index.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (rx_data == CH_CODES[8*k +: 8]) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(k);
        end
      end
    end
  end

  logic [7:0] err_inc;
  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  logic done_now;
  logic timeout_now;
  assign done_now    = ch_done[idx_q];
  assign timeout_now = TIMEOUT_EN && (timer_q == TIMER_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_d   = fsm_q;
    idx_d   = idx_q;
    act_d   = act_q;
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    txd_d   = txd_q;   // tx_data holds unless something drives it
    txs_d   = 1'b0;
`ifdef CMD_DISPATCHER_ACK_EN
    reply_d = reply_q;
    sent_d  = sent_q;
`endif

    unique case (fsm_q)
      S_IDLE: begin
        if (rx_ready) begin
          if (hit) begin
            fsm_d   = S_ACTIVE;
            idx_d   = hit_idx;
            act_d   = NUM_CH'(1) << hit_idx;
            state_d = rx_data;
            timer_d = '0;
          end else begin
            err_d = err_inc;
`ifdef CMD_DISPATCHER_ACK_EN
            fsm_d   = S_REPLY;
            reply_d = BYTE_NAK;
            sent_d  = 1'b0;
`endif
          end
        end
      end

      S_ACTIVE: begin
        // The active channel owns the transmitter; rx_ready is ignored here.
        txd_d = ch_bytes[idx_q];
        txs_d = ch_tx_start[idx_q];

        if (done_now || timeout_now) begin
          act_d   = '0;
          state_d = IDLE_CODE;
          fsm_d   = S_IDLE;
          // Done has priority over a coincident timeout.
          if (!done_now) begin
            err_d = err_inc;
          end
`ifdef CMD_DISPATCHER_ACK_EN
          fsm_d   = S_REPLY;
          reply_d = done_now ? BYTE_ACK : BYTE_CAN;
          sent_d  = 1'b0;
`endif
        end else if (TIMEOUT_EN) begin
          timer_d = timer_q + 1'b1;
        end
      end

`ifdef CMD_DISPATCHER_ACK_EN
      S_REPLY: begin
        // Wait for a free transmitter, strobe the byte once, then wait for
        // the transmitter to report completion.
        if (!sent_q) begin
          if (!tx_active) begin
            txd_d  = reply_q;
            txs_d  = 1'b1;
            sent_d = 1'b1;
          end
        end else if (tx_done) begin
          fsm_d = S_IDLE;
        end
      end
`endif

      default: begin
        fsm_d   = S_IDLE;
        act_d   = '0;
        state_d = IDLE_CODE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= S_IDLE;
      idx_q   <= '0;
      act_q   <= '0;
      state_q <= IDLE_CODE;
      timer_q <= '0;
      err_q   <= '0;
      txd_q   <= '0;
      txs_q   <= 1'b0;
`ifdef CMD_DISPATCHER_ACK_EN
      reply_q <= '0;
      sent_q  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values computed above.
      fsm_q   <= fsm_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      txd_q   <= txd_d;
      txs_q   <= txs_d;
`ifdef CMD_DISPATCHER_ACK_EN
      reply_q <= reply_d;
      sent_q  <= sent_d;
`endif
    end
  end

  assign ch_activate = act_q;
  assign state       = state_q;
  assign busy        = (fsm_q != S_IDLE);
  assign err_count   = err_q;
  assign tx_data     = txd_q;
  assign tx_start    = txs_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_cmd_dispatcher
//
// Directed bench for cmd_dispatcher in its default build (no reply state).
// Codes: ch0=0x11, ch1=0x21, ch2=0x71, ch3=0x72. Timeout shortened to 100.
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_cmd_dispatcher;

  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rx_ready = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic [NUM_CH-1:0] ch_activate;
  logic [NUM_CH-1:0] ch_done = '0;
  logic [NUM_CH*8-1:0] ch_tx_data = '0;
  logic [NUM_CH-1:0] ch_tx_start = '0;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_active = 1'b0;
  logic              tx_done = 1'b0;
  logic [7:0]        state;
  logic              busy;
  logic [7:0]        err_count;

  int checks = 0;
  int errors = 0;

  cmd_dispatcher #(
    .NUM_CH         (NUM_CH),
    .CH_CODES       ({8'h72, 8'h71, 8'h21, 8'h11}),
    .IDLE_CODE      (8'hFF),
    .TIMEOUT_CYCLES (100),
    .TIMEOUT_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .ch_activate (ch_activate),
    .ch_done     (ch_done),
    .ch_tx_data  (ch_tx_data),
    .ch_tx_start (ch_tx_start),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .state       (state),
    .busy        (busy),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, returning at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    // ---- Reset state ----
    tick();
    tick();
    check("rst_activate", ch_activate, 4'b0000);
    check("rst_state",    state,       8'hFF);
    check("rst_busy",     busy,        1'b0);
    check("rst_err",      err_count,   8'd0);
    check("rst_txd",      tx_data,     8'h00);
    check("rst_txs",      tx_start,    1'b0);
    reset = 1'b1;
    tick();

    // ---- 0x71 selects channel 2 ----
    send(8'h71);
    check("act71_activate", ch_activate, 4'b0100);
    check("act71_state",    state,       8'h71);
    check("act71_busy",     busy,        1'b1);
    // done from an inactive channel is ignored
    ch_done = 4'b0001;
    tick();
    check("foreign_done", ch_activate, 4'b0100);
    ch_done = 4'b0100;
    tick();
    ch_done = '0;
    check("done2_activate", ch_activate, 4'b0000);
    check("done2_state",    state,       8'hFF);
    check("done2_busy",     busy,        1'b0);

    // ---- unknown codes, including IDLE_CODE itself ----
    send(8'h33);
    check("unk33_activate", ch_activate, 4'b0000);
    check("unk33_err",      err_count,   8'd1);
    check("unk33_txs",      tx_start,    1'b0);
    send(8'hFF);
    check("unkFF_err",      err_count,   8'd2);
    check("unkFF_state",    state,       8'hFF);

    // ---- TX mux: channel 3 active, channel 2 also strobing ----
    send(8'h72);
    check("act72_activate", ch_activate, 4'b1000);
    ch_tx_data  = {8'hA5, 8'h5A, 8'h00, 8'h00};
    ch_tx_start = 4'b1100;
    tick();
    check("mux_txs", tx_start, 1'b1);
    check("mux_txd", tx_data,  8'hA5);
    ch_tx_start = 4'b0100;
    tick();
    check("mux_foreign_txs", tx_start, 1'b0);
    check("mux_foreign_txd", tx_data,  8'hA5);
    ch_tx_start = '0;
    ch_done     = 4'b1000;
    tick();
    ch_done = '0;
    check("done3_activate", ch_activate, 4'b0000);
    ch_tx_data = {8'h3C, 8'h5A, 8'h00, 8'h00};
    ch_tx_start = 4'b1000;
    tick();
    ch_tx_start = '0;
    check("idle_txd_hold", tx_data,  8'hA5);
    check("idle_txs_zero", tx_start, 1'b0);

    // ---- rx_ready ignored while a channel is active ----
    send(8'h11);
    check("act11_activate", ch_activate, 4'b0001);
    send(8'h72);
    check("ign_activate", ch_activate, 4'b0001);
    check("ign_state",    state,       8'h11);
    // rx_ready coincident with done is dropped
    ch_done = 4'b0001;
    send(8'h21);
    ch_done = '0;
    check("coinc_activate", ch_activate, 4'b0000);
    tick();
    check("coinc_dropped", ch_activate, 4'b0000);
    check("coinc_err",     err_count,   8'd2);

    // ---- timeout: falls after edge 100 counted from activation ----
    send(8'h11);
    for (int i = 0; i < 99; i++) tick();
    check("to_still_active", ch_activate, 4'b0001);
    tick();
    check("to_activate", ch_activate, 4'b0000);
    check("to_state",    state,       8'hFF);
    check("to_err",      err_count,   8'd3);

    // ---- done and timeout on the same edge: done wins ----
    send(8'h11);
    for (int i = 0; i < 99; i++) tick();
    ch_done = 4'b0001;
    tick();
    ch_done = '0;
    check("tie_activate", ch_activate, 4'b0000);
    check("tie_err",      err_count,   8'd3);

    // ---- asynchronous reset mid-operation ----
    send(8'h21);
    check("act21_activate", ch_activate, 4'b0010);
    #1;
    reset = 1'b0;
    #1;
    check("arst_activate", ch_activate, 4'b0000);
    check("arst_state",    state,       8'hFF);
    check("arst_busy",     busy,        1'b0);
    check("arst_err",      err_count,   8'd0);
    check("arst_txd",      tx_data,     8'h00);
    @(negedge clk);
    reset = 1'b1;
    tick();
    send(8'h21);
    check("post_activate", ch_activate, 4'b0010);
    check("post_state",    state,       8'h21);
    ch_done = 4'b0010;
    tick();
    ch_done = '0;
    check("post_done", ch_activate, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
